// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the burst-RAM arbiter: FSM state encoding, RAM command codes and
// a width helper.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } arb_state_e;

    localparam logic CmdRead  = 1'b0;
    localparam logic CmdWrite = 1'b1;

    // Width of an index or counter that must hold 0..n-1. Never returns less than 1.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Client-side and burst-RAM-side signals of the arbiter. Client vectors are packed, with
// client i in slice i. The slave view is the arbiter; the master view is the environment,
// which drives the client requests and the RAM responses.
interface burst_ram_arbiter_if #(
    parameter int unsigned NUM_CLIENTS             = 2,
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int unsigned MaskW = RAM_BURST_DATA_BITWIDTH / 8;

    logic [NUM_CLIENTS-1:0]                         c_req;
    logic [NUM_CLIENTS-1:0]                         c_cmd;
    logic [NUM_CLIENTS*RAM_DEPTH_BITWIDTH-1:0]      c_addr;
    logic [NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH-1:0] c_wr_data;
    logic [NUM_CLIENTS*MaskW-1:0]                   c_data_mask;
    logic [NUM_CLIENTS-1:0]                         c_gnt;
    logic [NUM_CLIENTS-1:0]                         c_rd_data_valid;
    logic [NUM_CLIENTS-1:0]                         c_busy;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]             rd_data;

    logic                                           br_cmd;
    logic                                           br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]                  br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]             br_wr_data;
    logic [MaskW-1:0]                               br_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]             br_rd_data;
    logic                                           br_rd_data_valid;
    logic                                           br_busy;

    modport master (
        output c_req, c_cmd, c_addr, c_wr_data, c_data_mask,
        input  c_gnt, c_rd_data_valid, c_busy, rd_data,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy
    );

    modport slave (
        input  c_req, c_cmd, c_addr, c_wr_data, c_data_mask,
        output c_gnt, c_rd_data_valid, c_busy, rd_data,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  br_rd_data, br_rd_data_valid, br_busy
    );

endinterface

// File: rtl/burst_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last owner and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned IDX_W       = 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last_owner,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_valid
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // First requester found walking forward from last_owner+1 wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            cand = 32'(last_owner) + k;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid     = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one burst RAM between NUM_CLIENTS clients. One burst at a time: a round-robin grant
// in IDLE, then either COUNT write beats (the first in the grant cycle) or COUNT read beats
// routed back to the owner only.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS             = 2,
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
    input logic                clk,
    input logic                rst,
    burst_ram_arbiter_if.slave bus
);

    localparam int unsigned AW    = RAM_DEPTH_BITWIDTH;
    localparam int unsigned DW    = RAM_BURST_DATA_BITWIDTH;
    localparam int unsigned MaskW = DW / 8;
    localparam int unsigned IdxW  = idx_width(NUM_CLIENTS);
    localparam int unsigned CntW  = idx_width(RAM_BURST_DATA_COUNT);
    localparam logic [CntW-1:0] LastBeat = CntW'(RAM_BURST_DATA_COUNT - 1);

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [IdxW-1:0]  last_owner_q, last_owner_d;

    logic [NUM_CLIENTS-1:0] win_gnt;
    logic [IdxW-1:0]        win_idx;
    logic                   win_valid;

    logic [AW-1:0]    addr_arr [NUM_CLIENTS];
    logic [DW-1:0]    wdata_arr[NUM_CLIENTS];
    logic [MaskW-1:0] mask_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
        assign addr_arr[g]   = bus.c_addr[g*AW +: AW];
        assign wdata_arr[g]  = bus.c_wr_data[g*DW +: DW];
        assign mask_arr[g]   = bus.c_data_mask[g*MaskW +: MaskW];
        assign bus.c_busy[g] = (state_q != StIdle) && (owner_q != IdxW'(g));
    end

    rr_arbiter #(
        .NUM_CLIENTS(NUM_CLIENTS),
        .IDX_W      (IdxW)
    ) u_rr_arbiter (
        .req       (bus.c_req),
        .last_owner(last_owner_q),
        .gnt       (win_gnt),
        .gnt_idx   (win_idx),
        .gnt_valid (win_valid)
    );

    assign bus.rd_data = bus.br_rd_data;

    // State, beat counter and ownership registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IdxW'(NUM_CLIENTS - 1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next state plus RAM command/data and client grant/valid outputs.
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        owner_d              = owner_q;
        last_owner_d         = last_owner_q;
        bus.c_gnt            = '0;
        bus.c_rd_data_valid  = '0;
        bus.br_cmd           = CmdRead;
        bus.br_cmd_en        = 1'b0;
        bus.br_addr          = '0;
        bus.br_wr_data       = '0;
        bus.br_data_mask     = '1;
        unique case (state_q)
            StIdle: begin
                // Gated by rst so nothing is granted while reset is held.
                if (!rst && win_valid && !bus.br_busy) begin
                    bus.c_gnt     = win_gnt;
                    bus.br_cmd_en = 1'b1;
                    bus.br_cmd    = bus.c_cmd[win_idx];
                    bus.br_addr   = addr_arr[win_idx];
                    owner_d       = win_idx;
                    last_owner_d  = win_idx;
                    cnt_d         = '0;
                    if (bus.c_cmd[win_idx] == CmdWrite) begin
                        // Beat 0 goes out alongside the command.
                        bus.br_wr_data   = wdata_arr[win_idx];
                        bus.br_data_mask = mask_arr[win_idx];
                        if (RAM_BURST_DATA_COUNT > 1) begin
                            state_d = StWrite;
                            cnt_d   = CntW'(1);
                        end
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                bus.br_wr_data   = wdata_arr[owner_q];
                bus.br_data_mask = mask_arr[owner_q];
                if (cnt_q == LastBeat) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRead: begin
                if (bus.br_rd_data_valid) begin
                    bus.c_rd_data_valid[owner_q] = 1'b1;
                    if (cnt_q == LastBeat) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: a 2-client instance for the main scenarios and a
// 4-client instance for the round-robin order.
module tb_burst_ram_arbiter;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned CNT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.NUM_CLIENTS(2), .RAM_DEPTH_BITWIDTH(AW),
                           .RAM_BURST_DATA_BITWIDTH(DW)) bus2 ();
    burst_ram_arbiter_if #(.NUM_CLIENTS(4), .RAM_DEPTH_BITWIDTH(AW),
                           .RAM_BURST_DATA_BITWIDTH(DW)) bus4 ();

    burst_ram_arbiter #(
        .NUM_CLIENTS(2), .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_BITWIDTH(DW), .RAM_BURST_DATA_COUNT(CNT)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    burst_ram_arbiter #(
        .NUM_CLIENTS(4), .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_BITWIDTH(DW), .RAM_BURST_DATA_COUNT(CNT)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus2.c_req = '0; bus2.c_cmd = '0; bus2.c_addr = '0;
        bus2.c_wr_data = '0; bus2.c_data_mask = '0;
        bus2.br_rd_data = '0; bus2.br_rd_data_valid = 1'b0; bus2.br_busy = 1'b0;
        bus4.c_req = '0; bus4.c_cmd = '0; bus4.c_addr = '0;
        bus4.c_wr_data = '0; bus4.c_data_mask = '0;
        bus4.br_rd_data = '0; bus4.br_rd_data_valid = 1'b0; bus4.br_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.c_req = 2'b01;
        bus2.br_rd_data_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b00) begin errors++;
            $display("FAIL reset_gnt: got %b want 00", bus2.c_gnt); end
        checks++; if (bus2.br_cmd_en !== 1'b0) begin errors++;
            $display("FAIL reset_cmd_en: got %b want 0", bus2.br_cmd_en); end
        checks++; if (bus2.br_data_mask !== 8'hFF) begin errors++;
            $display("FAIL reset_mask: got %h want ff", bus2.br_data_mask); end
        checks++; if (bus2.br_wr_data !== 64'h0) begin errors++;
            $display("FAIL reset_wr_data: got %h want 0", bus2.br_wr_data); end
        checks++; if (bus2.c_busy !== 2'b00) begin errors++;
            $display("FAIL reset_busy: got %b want 00", bus2.c_busy); end
        checks++; if (bus2.c_rd_data_valid !== 2'b00) begin errors++;
            $display("FAIL reset_rd_valid: got %b want 00", bus2.c_rd_data_valid); end
        cyc();
        rst = 1'b0;
        bus2.c_req = 2'b00;
        bus2.br_rd_data_valid = 1'b0;
    endtask

    task automatic test_read();
        logic [4:0] pat;
        pat = 5'b11011;
        cyc();
        bus2.c_req = 2'b01; bus2.c_cmd = 2'b00; bus2.c_addr = {4'd9, 4'd3};
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b01) begin errors++;
            $display("FAIL read_gnt: got %b want 01", bus2.c_gnt); end
        checks++; if (bus2.br_cmd_en !== 1'b1 || bus2.br_cmd !== 1'b0) begin errors++;
            $display("FAIL read_cmd: got en=%b cmd=%b want en=1 cmd=0",
                     bus2.br_cmd_en, bus2.br_cmd); end
        checks++; if (bus2.br_addr !== 4'd3) begin errors++;
            $display("FAIL read_addr: got %0d want 3", bus2.br_addr); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) bus2.c_req = 2'b00;
            bus2.br_rd_data_valid = pat[i];
            bus2.br_rd_data = 64'h100 + 64'(i);
            @(negedge clk);
            checks++; if (bus2.c_busy !== 2'b10) begin errors++;
                $display("FAIL read_busy[%0d]: got %b want 10", i, bus2.c_busy); end
            checks++; if (bus2.c_rd_data_valid !== {1'b0, pat[i]}) begin errors++;
                $display("FAIL read_valid[%0d]: got %b want 0%b", i,
                         bus2.c_rd_data_valid, pat[i]); end
            checks++; if (bus2.rd_data !== 64'h100 + 64'(i)) begin errors++;
                $display("FAIL read_data[%0d]: got %h want %h", i, bus2.rd_data,
                         64'h100 + 64'(i)); end
            checks++; if (bus2.br_cmd_en !== 1'b0) begin errors++;
                $display("FAIL read_cmd_en[%0d]: got %b want 0", i, bus2.br_cmd_en); end
        end
        // Back in IDLE: a stray valid must not reach any client.
        cyc();
        bus2.br_rd_data_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus2.c_busy !== 2'b00) begin errors++;
            $display("FAIL read_idle_busy: got %b want 00", bus2.c_busy); end
        checks++; if (bus2.c_rd_data_valid !== 2'b00) begin errors++;
            $display("FAIL read_idle_valid: got %b want 00", bus2.c_rd_data_valid); end
        cyc();
        bus2.br_rd_data_valid = 1'b0;
    endtask

    task automatic test_write();
        bus2.c_req = 2'b10; bus2.c_cmd = 2'b10; bus2.c_addr = {4'd5, 4'd1};
        bus2.c_wr_data = {64'hA, 64'h55}; bus2.c_data_mask = {8'h0F, 8'h00};
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b10) begin errors++;
            $display("FAIL write_gnt: got %b want 10", bus2.c_gnt); end
        checks++; if (bus2.br_cmd_en !== 1'b1 || bus2.br_cmd !== 1'b1) begin errors++;
            $display("FAIL write_cmd: got en=%b cmd=%b want en=1 cmd=1",
                     bus2.br_cmd_en, bus2.br_cmd); end
        checks++; if (bus2.br_addr !== 4'd5) begin errors++;
            $display("FAIL write_addr: got %0d want 5", bus2.br_addr); end
        checks++; if (bus2.br_wr_data !== 64'hA || bus2.br_data_mask !== 8'h0F) begin errors++;
            $display("FAIL write_beat0: got %h/%h want a/0f", bus2.br_wr_data,
                     bus2.br_data_mask); end
        for (int i = 1; i < 4; i++) begin
            cyc();
            if (i == 1) bus2.c_req = 2'b00;
            bus2.c_wr_data = {64'hA + 64'(i), 64'h55};
            @(negedge clk);
            checks++; if (bus2.br_wr_data !== 64'hA + 64'(i)) begin errors++;
                $display("FAIL write_data[%0d]: got %h want %h", i, bus2.br_wr_data,
                         64'hA + 64'(i)); end
            checks++; if (bus2.br_data_mask !== 8'h0F) begin errors++;
                $display("FAIL write_mask[%0d]: got %h want 0f", i, bus2.br_data_mask); end
            checks++; if (bus2.c_busy !== 2'b01) begin errors++;
                $display("FAIL write_busy[%0d]: got %b want 01", i, bus2.c_busy); end
            checks++; if (bus2.br_cmd_en !== 1'b0 || bus2.c_gnt !== 2'b00) begin errors++;
                $display("FAIL write_no_cmd[%0d]: got en=%b gnt=%b want 0/00", i,
                         bus2.br_cmd_en, bus2.c_gnt); end
        end
        cyc();
        bus2.c_wr_data = {64'hEE, 64'h55};
        @(negedge clk);
        checks++; if (bus2.br_wr_data !== 64'h0 || bus2.br_data_mask !== 8'hFF) begin errors++;
            $display("FAIL write_idle_bus: got %h/%h want 0/ff", bus2.br_wr_data,
                     bus2.br_data_mask); end
        checks++; if (bus2.c_busy !== 2'b00) begin errors++;
            $display("FAIL write_idle_busy: got %b want 00", bus2.c_busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic [1:0] exp_busy;
        int own;
        cyc();
        bus2.c_req = 2'b11; bus2.c_cmd = 2'b11;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            own = (c / 4) % 2;
            exp_gnt  = (c % 4 == 0) ? (2'b01 << own) : 2'b00;
            exp_busy = (c % 4 == 0) ? 2'b00 : (2'b01 << (1 - own));
            checks++; if (bus2.c_gnt !== exp_gnt) begin errors++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", c, bus2.c_gnt, exp_gnt); end
            checks++; if (bus2.c_busy !== exp_busy) begin errors++;
                $display("FAIL b2b_busy[%0d]: got %b want %b", c, bus2.c_busy, exp_busy); end
        end
        cyc();
        bus2.c_req = 2'b00;
    endtask

    task automatic test_br_busy();
        bus2.br_busy = 1'b1;
        bus2.c_req = 2'b10; bus2.c_cmd = 2'b00; bus2.c_addr = {4'd7, 4'd0};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            checks++; if (bus2.c_gnt !== 2'b00 || bus2.br_cmd_en !== 1'b0) begin errors++;
                $display("FAIL busy_hold[%0d]: got gnt=%b en=%b want 00/0", i,
                         bus2.c_gnt, bus2.br_cmd_en); end
        end
        cyc();
        bus2.br_busy = 1'b0;
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b10 || bus2.br_cmd_en !== 1'b1) begin errors++;
            $display("FAIL busy_release: got gnt=%b en=%b want 10/1", bus2.c_gnt,
                     bus2.br_cmd_en); end
        checks++; if (bus2.br_addr !== 4'd7) begin errors++;
            $display("FAIL busy_addr: got %0d want 7", bus2.br_addr); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) bus2.c_req = 2'b00;
            bus2.br_rd_data_valid = 1'b1;
            @(negedge clk);
            checks++; if (bus2.c_rd_data_valid !== 2'b10) begin errors++;
                $display("FAIL busy_read_valid[%0d]: got %b want 10", i,
                         bus2.c_rd_data_valid); end
        end
        cyc();
        bus2.br_rd_data_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bus2.c_req = 2'b01; bus2.c_cmd = 2'b00; bus2.c_addr = {4'd0, 4'd2};
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b01) begin errors++;
            $display("FAIL mid_gnt: got %b want 01", bus2.c_gnt); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (i == 0) bus2.c_req = 2'b00;
            bus2.br_rd_data_valid = 1'b1;
            @(negedge clk);
            checks++; if (bus2.c_rd_data_valid !== 2'b01) begin errors++;
                $display("FAIL mid_valid[%0d]: got %b want 01", i, bus2.c_rd_data_valid); end
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (bus2.c_rd_data_valid !== 2'b00 || bus2.c_busy !== 2'b00) begin errors++;
            $display("FAIL mid_rst_outputs: got valid=%b busy=%b want 00/00",
                     bus2.c_rd_data_valid, bus2.c_busy); end
        checks++; if (bus2.br_cmd_en !== 1'b0 || bus2.br_data_mask !== 8'hFF) begin errors++;
            $display("FAIL mid_rst_bus: got en=%b mask=%h want 0/ff", bus2.br_cmd_en,
                     bus2.br_data_mask); end
        cyc();
        rst = 1'b0;
        bus2.c_req = 2'b11; bus2.c_cmd = 2'b00;
        @(negedge clk);
        checks++; if (bus2.c_gnt !== 2'b01) begin errors++;
            $display("FAIL mid_regrant: got %b want 01", bus2.c_gnt); end
        checks++; if (bus2.c_rd_data_valid !== 2'b00) begin errors++;
            $display("FAIL mid_stray_valid: got %b want 00", bus2.c_rd_data_valid); end
        // Fresh read must take all four beats, proving the beat counter restarted.
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) bus2.c_req = 2'b00;
            @(negedge clk);
            checks++; if (bus2.c_rd_data_valid !== 2'b01 || bus2.c_busy !== 2'b10) begin
                errors++;
                $display("FAIL mid_reread[%0d]: got valid=%b busy=%b want 01/10", i,
                         bus2.c_rd_data_valid, bus2.c_busy); end
        end
        cyc();
        bus2.br_rd_data_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus2.c_busy !== 2'b00) begin errors++;
            $display("FAIL mid_reread_done: got %b want 00", bus2.c_busy); end
    endtask

    task automatic test_four_clients();
        logic [3:0] exp_gnt;
        logic [3:0] owner_bit;
        cyc();
        bus4.c_req = 4'hF; bus4.c_cmd = 4'hF;
        for (int c = 0; c < 17; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            owner_bit = 4'b0001 << ((c / 4) % 4);
            exp_gnt = (c % 4 == 0) ? owner_bit : 4'b0000;
            checks++; if (bus4.c_gnt !== exp_gnt) begin errors++;
                $display("FAIL rr4_gnt[%0d]: got %b want %b", c, bus4.c_gnt, exp_gnt); end
            if (c % 4 == 2) begin
                checks++; if (bus4.c_busy !== ~owner_bit) begin errors++;
                    $display("FAIL rr4_busy[%0d]: got %b want %b", c, bus4.c_busy,
                             ~owner_bit); end
            end
        end
        cyc();
        bus4.c_req = 4'h0;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_br_busy();
        test_reset_mid_burst();
        test_four_clients();
        repeat (8) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of client ports (2..8).
REQ-002 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4, burst RAM address width.
REQ-003 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64, beat width.
REQ-004 SHALL have parameter RAM_BURST_DATA_COUNT, default 4, beats per burst.
REQ-005 SHALL have ports, client vectors packed with client i at slice i:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- c_req  in  NUM_CLIENTS  request level, held until grant
- c_cmd  in  NUM_CLIENTS  0=read, 1=write
- c_addr  in  NUM_CLIENTS*RAM_DEPTH_BITWIDTH  burst address
- c_wr_data  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH  write beat
- c_data_mask  in  NUM_CLIENTS*RAM_BURST_DATA_BITWIDTH/8  byte mask, 1=masked
- c_gnt  out  NUM_CLIENTS  one-cycle grant pulse
- c_rd_data_valid  out  NUM_CLIENTS  read beat valid, owner only
- c_busy  out  NUM_CLIENTS  transaction in progress for non-owner
- rd_data  out  RAM_BURST_DATA_BITWIDTH  br_rd_data broadcast to all clients
- br_cmd, br_cmd_en  out  1  RAM command and strobe
- br_addr  out  RAM_DEPTH_BITWIDTH
- br_wr_data, br_data_mask  out  burst width and width/8
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH
- br_rd_data_valid, br_busy  in  1

Function
REQ-006 SHALL implement states IDLE, READ, WRITE in a registered FSM.
REQ-007 IDLE: if any c_req and br_busy=0, pick winner by round-robin, pulse c_gnt[winner] and br_cmd_en for exactly one cycle, drive br_cmd/br_addr from winner combinationally in that cycle.
REQ-008 Round-robin: search starts at (last_owner+1) mod NUM_CLIENTS; last_owner resets to NUM_CLIENTS-1, so client 0 wins the first tie.
REQ-009 In the grant cycle, c_cmd=0 SHALL move to READ and c_cmd=1 to WRITE; owner index is registered.
REQ-010 WRITE: beat 0 is forwarded on the grant cycle, beats 1..COUNT-1 on the following cycles from the owner's c_wr_data/c_data_mask; after the last beat return to IDLE (WRITE lasts COUNT-1 cycles).
REQ-011 READ: route br_rd_data_valid only to c_rd_data_valid[owner]; count beats; return to IDLE in the cycle after the COUNT-th valid beat.
REQ-012 br_rd_data_valid in IDLE or WRITE SHALL be ignored (no client valid).
REQ-013 br_cmd_en SHALL never assert while br_busy=1 or while the FSM is not in IDLE.
REQ-014 br_wr_data/br_data_mask SHALL be 0 / all-ones (fully masked) outside write beats; br_cmd_en=0 otherwise.
REQ-015 c_busy[i] SHALL be 1 when the FSM is not IDLE and i is not the owner.
REQ-016 A req deasserted before grant SHALL be dropped without side effect; c_req asserted by the owner during its own transaction SHALL be re-arbitrated only in IDLE.
REQ-017 Beat counter width SHALL be clog2(RAM_BURST_DATA_COUNT), wrapping to 0 at the end of each burst.

Reset
REQ-018 Asynchronous reset SHALL force IDLE, counter 0, owner 0, last_owner NUM_CLIENTS-1, all c_gnt/c_rd_data_valid/c_busy/br_cmd_en 0, br_data_mask all-ones.
REQ-019 Reset mid-burst SHALL abandon the transaction; post-reset read beats are dropped per REQ-012.

Structure
REQ-020 SHALL place state encoding (IDLE/READ/WRITE) and the command constants (READ=0, WRITE=1) in the shared burst-RAM package.
REQ-021 SHALL contain one sub-module rr_arbiter (NUM_CLIENTS request vector, last_owner in -> one-hot grant plus index out, combinational).

Verification
REQ-022 Single client 0 read at addr 3, RAM returns 4 beats -> br_cmd_en one cycle with br_addr=3, c_rd_data_valid[0] pulses 4 times, c_rd_data_valid[1] stays 0, IDLE after.
REQ-023 Client 1 write, beats 0xA..0xD, mask 0x0F -> br_wr_data 0xA,0xB,0xC,0xD on 4 consecutive cycles from the grant cycle, mask 0x0F on each beat.
REQ-024 Both clients request continuously -> grants alternate 0,1,0,1, no overlap, c_busy set on the non-owner.
REQ-025 br_busy=1 with pending req -> no grant until br_busy falls; grant on the first cycle with br_busy=0.
REQ-026 rst asserted after 2 of 4 read beats -> all outputs reset immediately, remaining beats ignored, next request granted to client 0.
REQ-027 NUM_CLIENTS=4, all request -> grant order 0,1,2,3,0.
